// File: rtl/decode_issue_ctrl.sv
// Decode-side scoreboard and registered issue slot toward execute; stalls decode on RAW/WAW or back-pressure.
// Build macro DECODE_ISSUE_WB_BYPASS_EN: a writeback in the same cycle releases the hazard immediately.
module decode_issue_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_wr_rd,
    output logic             id_ready,
    output logic             issue_valid,
    output logic [4:0]       issue_rd,
    input  logic             ex_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [5:0]       busy_count,
    output logic [CNT_W-1:0] stall_cycles
);

    // Bit 0 exists only to allow direct indexing by register id; it is never set.
    logic [31:0] busy;
    logic [31:0] busy_eff;
    logic [31:0] busy_nxt;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        hazard_waw;
    logic        slot_block;
    logic        fire;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

`ifdef DECODE_ISSUE_WB_BYPASS_EN
    always_comb begin
        busy_eff = busy;
        if (wb_valid) begin
            busy_eff[wb_rd] = 1'b0;
        end
    end
`else
    assign busy_eff = busy;
`endif

    assign hazard_rs1 = id_use_rs1 && (id_rs1 != 5'd0) && busy_eff[id_rs1];
    assign hazard_rs2 = id_use_rs2 && (id_rs2 != 5'd0) && busy_eff[id_rs2];
    assign hazard_waw = id_wr_rd   && (id_rd  != 5'd0) && busy_eff[id_rd];
    assign slot_block = issue_valid && !ex_ready;

    assign id_ready = reset_n && !flush && !hazard_rs1 && !hazard_rs2 && !hazard_waw && !slot_block;
    assign fire     = id_valid && id_ready;

    // Set is applied after clear so a new producer of the written-back register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wb_valid && (wb_rd != 5'd0)) begin
                busy_nxt[wb_rd] = 1'b0;
            end
            if (fire && id_wr_rd && (id_rd != 5'd0)) begin
                busy_nxt[id_rd] = 1'b1;
            end
        end
    end

    // State update boundary: scoreboard, issue slot and stall counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy         <= '0;
            busy_count   <= '0;
            issue_valid  <= 1'b0;
            issue_rd     <= '0;
            stall_cycles <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
            if (flush) begin
                issue_valid <= 1'b0;
            end else if (fire) begin
                issue_valid <= 1'b1;
                issue_rd    <= id_wr_rd ? id_rd : 5'd0;
            end else if (ex_ready) begin
                issue_valid <= 1'b0;
            end
            if (id_valid && !id_ready && !flush) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: directed scenarios plus randomized traffic against a scoreboard model.
module tb_decode_issue_ctrl;
    localparam int CNT_W = 32;
`ifdef DECODE_ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_wr_rd;
    logic             id_ready;
    logic             issue_valid;
    logic [4:0]       issue_rd;
    logic             ex_ready;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             flush;
    logic [5:0]       busy_count;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    decode_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_wr_rd     (id_wr_rd),
        .id_ready     (id_ready),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .ex_ready     (ex_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .busy_count   (busy_count),
        .stall_cycles (stall_cycles)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: set of registers with a write in flight, the issue slot, and the stall count.
    bit              m_busy [32];
    bit              m_iv;
    logic [4:0]      m_ird;
    longint unsigned m_stall;
    bit              m_ready;

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (BYP && wb_valid && wb_rd == r) return 1'b0;
        return m_busy[r];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 1; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic void model_eval();
        m_ready = reset_n && !flush
                  && !(id_use_rs1 && pending(id_rs1))
                  && !(id_use_rs2 && pending(id_rs2))
                  && !(id_wr_rd   && pending(id_rd))
                  && !(m_iv && !ex_ready);
    endfunction

    task automatic tick();
        bit fire;
        model_eval();
        fire = id_valid && m_ready;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_iv    = 1'b0;
            m_ird   = 5'd0;
            m_stall = 0;
        end else begin
            if (id_valid && !m_ready && !flush && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
                m_iv = 1'b0;
            end else begin
                if (wb_valid && wb_rd != 5'd0) m_busy[wb_rd] = 1'b0;
                if (fire && id_wr_rd && id_rd != 5'd0) m_busy[id_rd] = 1'b1;
                if (fire) begin
                    m_iv  = 1'b1;
                    m_ird = id_wr_rd ? id_rd : 5'd0;
                end else if (ex_ready) begin
                    m_iv = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_wr_rd = 0;
        ex_ready = 1; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic drive_id(input logic [4:0] rs1, input bit u1, input logic [4:0] rd, input bit w);
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = 0; id_use_rs2 = 0;
        id_rd = rd; id_wr_rd = w;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd3; ex_ready = 0;
        #1;
        n_total++; if (id_ready !== 1'b0) $display("FAIL reset_ready0: got %b want 0", id_ready); else n_pass++;
        tick();
        n_total++; if (id_ready !== 1'b0) $display("FAIL reset_ready1: got %b want 0", id_ready); else n_pass++;
        tick();
        n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %b want 0", issue_valid); else n_pass++;
        n_total++; if (issue_rd !== 5'd0) $display("FAIL reset_issue_rd: got %0d want 0", issue_rd); else n_pass++;
        n_total++; if (busy_count !== 6'd0) $display("FAIL reset_busy_count: got %0d want 0", busy_count); else n_pass++;
        n_total++; if (stall_cycles !== '0) $display("FAIL reset_stall: got %0d want 0", stall_cycles); else n_pass++;
        reset_n = 1;
        idle();
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        drive_id(5'd0, 0, 5'd5, 1);
        #1;
        n_total++; if (id_ready !== 1'b1) $display("FAIL raw_producer_ready: got %b want 1", id_ready); else n_pass++;
        tick();
        n_total++; if (busy_count !== 6'd1) $display("FAIL raw_busy_count: got %0d want 1", busy_count); else n_pass++;
        n_total++; if (issue_rd !== 5'd5) $display("FAIL raw_issue_rd: got %0d want 5", issue_rd); else n_pass++;
        drive_id(5'd5, 1, 5'd6, 1);
        for (int k = 1; k <= 2; k++) begin
            #1;
            n_total++; if (id_ready !== 1'b0) $display("FAIL raw_stall_ready: got %b want 0", id_ready); else n_pass++;
            tick();
            n_total++; if (stall_cycles !== CNT_W'(k)) $display("FAIL raw_stall_count: got %0d want %0d", stall_cycles, k); else n_pass++;
        end
        wb_valid = 1; wb_rd = 5'd5;
        #1;
        n_total++; if (id_ready !== BYP) $display("FAIL raw_wb_cycle_ready: got %b want %b", id_ready, BYP); else n_pass++;
        tick();
        wb_valid = 0;
        if (!BYP) begin
            #1;
            n_total++; if (id_ready !== 1'b1) $display("FAIL raw_after_wb_ready: got %b want 1", id_ready); else n_pass++;
            tick();
        end
        n_total++; if (issue_rd !== 5'd6) $display("FAIL raw_consumer_issue_rd: got %0d want 6", issue_rd); else n_pass++;
        n_total++; if (busy_count !== 6'd1) $display("FAIL raw_final_busy: got %0d want 1", busy_count); else n_pass++;
        n_total++; if (stall_cycles !== (BYP ? CNT_W'(2) : CNT_W'(3))) $display("FAIL raw_final_stall: got %0d want %0d", stall_cycles, BYP ? 2 : 3); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        drive_id(5'd0, 0, 5'd0, 1);
        #1;
        n_total++; if (id_ready !== 1'b1) $display("FAIL x0_write_ready: got %b want 1", id_ready); else n_pass++;
        tick();
        n_total++; if (busy_count !== 6'd0) $display("FAIL x0_busy_count: got %0d want 0", busy_count); else n_pass++;
        n_total++; if (issue_valid !== 1'b1 || issue_rd !== 5'd0) $display("FAIL x0_issue: got v=%b rd=%0d want v=1 rd=0", issue_valid, issue_rd); else n_pass++;
        drive_id(5'd0, 1, 5'd0, 0);
        #1;
        n_total++; if (id_ready !== 1'b1) $display("FAIL x0_read_ready: got %b want 1", id_ready); else n_pass++;
        tick();
        n_total++; if (stall_cycles !== '0 || busy_count !== 6'd0) $display("FAIL x0_no_stall: got stall=%0d busy=%0d want 0/0", stall_cycles, busy_count); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        drive_id(5'd0, 0, 5'd9, 1);
        tick();
        ex_ready = 0;
        drive_id(5'd0, 0, 5'd10, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++; if (id_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", id_ready); else n_pass++;
            tick();
            n_total++; if (issue_valid !== 1'b1 || issue_rd !== 5'd9) $display("FAIL bp_hold: got v=%b rd=%0d want v=1 rd=9", issue_valid, issue_rd); else n_pass++;
        end
        ex_ready = 1;
        #1;
        n_total++; if (id_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", id_ready); else n_pass++;
        tick();
        n_total++; if (issue_rd !== 5'd10) $display("FAIL bp_next_issue_rd: got %0d want 10", issue_rd); else n_pass++;
        n_total++; if (stall_cycles !== CNT_W'(3)) $display("FAIL bp_stall: got %0d want 3", stall_cycles); else n_pass++;
        n_total++; if (busy_count !== 6'd2) $display("FAIL bp_busy: got %0d want 2", busy_count); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_wb_same_reg();
        do_reset();
        drive_id(5'd0, 0, 5'd7, 1);
        tick();
        wb_valid = 1; wb_rd = 5'd7;
        #1;
        n_total++; if (id_ready !== BYP) $display("FAIL same_wb_ready: got %b want %b", id_ready, BYP); else n_pass++;
        tick();
        wb_valid = 0;
        n_total++; if (busy_count !== (BYP ? 6'd1 : 6'd0)) $display("FAIL same_wb_busy: got %0d want %0d", busy_count, BYP ? 1 : 0); else n_pass++;
        if (!BYP) tick();
        n_total++; if (busy_count !== 6'd1 || issue_rd !== 5'd7) $display("FAIL same_final: got busy=%0d rd=%0d want 1/7", busy_count, issue_rd); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive_id(5'd0, 0, 5'd3, 1);
        tick();
        drive_id(5'd0, 0, 5'd4, 1);
        tick();
        n_total++; if (busy_count !== 6'd2) $display("FAIL flush_pre_busy: got %0d want 2", busy_count); else n_pass++;
        ex_ready = 0; flush = 1;
        drive_id(5'd0, 0, 5'd8, 1);
        #1;
        n_total++; if (id_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", id_ready); else n_pass++;
        tick();
        flush = 0;
        n_total++; if (busy_count !== 6'd0 || issue_valid !== 1'b0) $display("FAIL flush_clear: got busy=%0d v=%b want 0/0", busy_count, issue_valid); else n_pass++;
        n_total++; if (stall_cycles !== '0) $display("FAIL flush_stall: got %0d want 0", stall_cycles); else n_pass++;
        drive_id(5'd3, 1, 5'd0, 0);
        #1;
        n_total++; if (id_ready !== 1'b1) $display("FAIL flush_after_ready: got %b want 1", id_ready); else n_pass++;
        tick();
        n_total++; if (issue_valid !== 1'b1) $display("FAIL flush_after_issue: got %b want 1", issue_valid); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset_n    = ($urandom_range(0, 99) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 7));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            id_wr_rd   = 1'($urandom_range(0, 1));
            ex_ready   = ($urandom_range(0, 9) < 7);
            wb_valid   = ($urandom_range(0, 9) < 4);
            wb_rd      = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 99) < 3);
            #1;
            model_eval();
            n_total++; if (id_ready !== m_ready) $display("FAIL rnd_ready c=%0d: got %b want %b", c, id_ready, m_ready); else n_pass++;
            tick();
            n_total++; if (issue_valid !== m_iv) $display("FAIL rnd_issue_valid c=%0d: got %b want %b", c, issue_valid, m_iv); else n_pass++;
            n_total++; if (issue_rd !== m_ird) $display("FAIL rnd_issue_rd c=%0d: got %0d want %0d", c, issue_rd, m_ird); else n_pass++;
            n_total++; if (busy_count !== 6'(m_count())) $display("FAIL rnd_busy_count c=%0d: got %0d want %0d", c, busy_count, m_count()); else n_pass++;
            n_total++; if (stall_cycles !== CNT_W'(m_stall)) $display("FAIL rnd_stall c=%0d: got %0d want %0d", c, stall_cycles, m_stall); else n_pass++;
        end
        reset_n = 1;
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_raw();
        test_x0();
        test_backpressure();
        test_wb_same_reg();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
